// File: rtl/parser_pkg.sv
// Shared types and constants for the parser front end: collector FSM states,
// VLAN field geometry and the segment-index width helper.
package parser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    localparam int VLAN_W            = 12;
    localparam int C_VLAN_OFFSET_DEF = 116;

    // Width able to hold a segment count of 0..n
    function automatic int seg_idx_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/parser_vlan_extract.sv
// Registers the VLAN ID of beat 0 and emits a one-cycle valid pulse.
// Instantiated by parser_seg_collector only when PARSER_SEG_VLAN_EN is defined.
module parser_vlan_extract
    import parser_pkg::*;
(
    input  logic              axis_clk,
    input  logic              aresetn,
    input  logic              capture,
    input  logic [VLAN_W-1:0] field,
    output logic [VLAN_W-1:0] vlan,
    output logic              vlan_valid
);

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            vlan       <= '0;
            vlan_valid <= 1'b0;
        end else begin
            vlan_valid <= capture;
            if (capture) begin
                vlan <= field;
            end
        end
    end

endmodule

// File: rtl/parser_seg_collector.sv
// Captures the first C_NUM_SEGS beats of an AXI4-Stream packet into one wide
// bundle, hands it off via valid/ready and drains the rest. VLAN extraction
// is enabled by the PARSER_SEG_VLAN_EN macro.
module parser_seg_collector
    import parser_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 4,
    parameter int C_VLAN_OFFSET      = C_VLAN_OFFSET_DEF
) (
    input  logic                                       axis_clk,
    input  logic                                       aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]               s_axis_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]              s_axis_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]             s_axis_tkeep,
    input  logic                                       s_axis_tvalid,
    input  logic                                       s_axis_tlast,
    output logic                                       s_axis_tready,
    input  logic                                       segs_ready,
    output logic                                       segs_valid,
    output logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0]    tdata_segs,
    output logic [C_AXIS_TUSER_WIDTH-1:0]              tuser_1st,
    output logic [seg_idx_w(C_NUM_SEGS)-1:0]           seg_cnt,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]             last_tkeep,
    output logic                                       truncated,
    output logic [VLAN_W-1:0]                          vlan,
    output logic                                       vlan_valid
);

    localparam int            W        = C_AXIS_DATA_WIDTH;
    localparam int            IW       = seg_idx_w(C_NUM_SEGS);
    localparam logic [IW-1:0] LAST_IDX = IW'(C_NUM_SEGS - 1);
    localparam bit            ONE_SEG  = (C_NUM_SEGS == 1);

    if (C_NUM_SEGS < 1 || C_NUM_SEGS > 8 ||
        C_VLAN_OFFSET + VLAN_W > C_AXIS_DATA_WIDTH) begin : g_param_check
        $error("parser_seg_collector: illegal parameter combination");
    end

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          fire, beat0, collect_wr, done;
    logic [W-1:0]  segs_q [C_NUM_SEGS];

    assign fire = s_axis_tvalid & ready_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    state_d = done ? (s_axis_tlast ? ST_IDLE : ST_DRAIN) : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (done) begin
                    state_d = s_axis_tlast ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fire && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is registered from next-state values so segs_ready never reaches
    // s_axis_tready combinationally.
    always_comb begin
        beat0      = fire && (state_q == ST_IDLE);
        collect_wr = fire && (state_q == ST_COLLECT);
        done       = (beat0 && (s_axis_tlast || ONE_SEG)) ||
                     (collect_wr && (s_axis_tlast || idx_q == LAST_IDX));
        valid_d    = valid_q;
        if (valid_q && segs_ready) begin
            valid_d = 1'b0;
        end
        if (done) begin
            valid_d = 1'b1;
        end
        ready_d = (state_d != ST_IDLE) || !valid_d;
    end

    // NOTE: the wide bundle register is reset because it drives output ports
    // that must read zero straight out of reset.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < C_NUM_SEGS; k++) begin
                segs_q[k] <= '0;
            end
            idx_q      <= '0;
            tuser_1st  <= '0;
            seg_cnt    <= '0;
            last_tkeep <= '0;
            truncated  <= 1'b0;
        end else begin
            if (beat0) begin
                for (int k = 0; k < C_NUM_SEGS; k++) begin
                    segs_q[k] <= (k == 0) ? s_axis_tdata : '0;
                end
                tuser_1st <= s_axis_tuser;
                idx_q     <= IW'(1);
            end else if (collect_wr) begin
                for (int k = 0; k < C_NUM_SEGS; k++) begin
                    if (k == int'(idx_q)) begin
                        segs_q[k] <= s_axis_tdata;
                    end
                end
                idx_q <= idx_q + IW'(1);
            end
            if (done) begin
                seg_cnt    <= beat0 ? IW'(1) : idx_q + IW'(1);
                last_tkeep <= s_axis_tkeep;
                truncated  <= !s_axis_tlast;
            end
        end
    end

    for (genvar k = 0; k < C_NUM_SEGS; k++) begin : g_pack
        assign tdata_segs[k*W +: W] = segs_q[k];
    end

    assign s_axis_tready = ready_q;
    assign segs_valid    = valid_q;

`ifdef PARSER_SEG_VLAN_EN
    parser_vlan_extract u_vlan (
        .axis_clk   (axis_clk),
        .aresetn    (aresetn),
        .capture    (beat0),
        .field      (s_axis_tdata[C_VLAN_OFFSET +: VLAN_W]),
        .vlan       (vlan),
        .vlan_valid (vlan_valid)
    );
`else
    assign vlan       = '0;
    assign vlan_valid = 1'b0;
`endif

endmodule

// File: tb/tb_parser_seg_collector.sv
// Self-checking bench for parser_seg_collector: directed cases plus random
// packets checked against a packet-level reference model.
module tb_parser_seg_collector;

    localparam int W  = 512;
    localparam int TU = 128;
    localparam int N  = 4;
    localparam int KW = W / 8;
    localparam int IW = $clog2(N + 1);
    localparam int VO = 116;

    logic              axis_clk = 1'b0;
    logic              aresetn  = 1'b0;
    logic [W-1:0]      s_axis_tdata = '0;
    logic [TU-1:0]     s_axis_tuser = '0;
    logic [KW-1:0]     s_axis_tkeep = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast  = 1'b0;
    logic              s_axis_tready;
    logic              segs_ready = 1'b0;
    logic              segs_valid;
    logic [N*W-1:0]    tdata_segs;
    logic [TU-1:0]     tuser_1st;
    logic [IW-1:0]     seg_cnt;
    logic [KW-1:0]     last_tkeep;
    logic              truncated;
    logic [11:0]       vlan;
    logic              vlan_valid;

    always #5 axis_clk = ~axis_clk;

    parser_seg_collector #(
        .C_AXIS_DATA_WIDTH  (W),
        .C_AXIS_TUSER_WIDTH (TU),
        .C_NUM_SEGS         (N),
        .C_VLAN_OFFSET      (VO)
    ) dut (
        .axis_clk      (axis_clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .segs_ready    (segs_ready),
        .segs_valid    (segs_valid),
        .tdata_segs    (tdata_segs),
        .tuser_1st     (tuser_1st),
        .seg_cnt       (seg_cnt),
        .last_tkeep    (last_tkeep),
        .truncated     (truncated),
        .vlan          (vlan),
        .vlan_valid    (vlan_valid)
    );

    int tests = 0;
    int fails = 0;

    // Reference packet: beats, keeps and tusers of the packet being sent
    logic [W-1:0]  pd [0:15];
    logic [KW-1:0] pk [0:15];
    logic [TU-1:0] pu [0:15];
    int            plen;
    logic [11:0]   exp_vlan = '0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic make_pkt(input int len);
        plen = len;
        for (int b = 0; b < len; b++) begin
            pd[b] = rand_beat();
            pk[b] = {$urandom, $urandom};
            pu[b] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic wait_accept(output int waits);
        waits = 0;
        forever begin
            @(negedge axis_clk);
            if (s_axis_tready) break;
            waits++;
            if (waits >= 64) begin
                tests++;
                fails++;
                $error("FAIL accept_timeout: observed tready=0 for %0d cycles expected 1", waits);
                break;
            end
        end
        @(posedge axis_clk);
        #1;
    endtask

    // Sends the first nbeats beats of the current reference packet
    task automatic send_pkt(input int nbeats);
        int w;
        int ncap;
        ncap = (plen < N) ? plen : N;
        for (int b = 0; b < nbeats; b++) begin
            s_axis_tdata  = pd[b];
            s_axis_tkeep  = pk[b];
            s_axis_tuser  = pu[b];
            s_axis_tlast  = (b == plen - 1);
            s_axis_tvalid = 1'b1;
            wait_accept(w);
            if (b > 0) check($sformatf("ready_mid_pkt_b%0d", b), 512'(w), 512'(0));
            if (b == 0) begin
`ifdef PARSER_SEG_VLAN_EN
                exp_vlan = pd[0][VO +: 12];
                check("vlan_valid_pulse", vlan_valid, 1'b1);
`else
                exp_vlan = '0;
                check("vlan_valid_off", vlan_valid, 1'b0);
`endif
                check("vlan_value", vlan, exp_vlan);
            end
            if (b < ncap - 1) check($sformatf("segs_valid_early_b%0d", b), segs_valid, 1'b0);
            if (b == ncap - 1) check("segs_valid_latency", segs_valid, 1'b1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic check_fields();
        int ncap;
        logic [W-1:0] exp_seg;
        ncap = (plen < N) ? plen : N;
        check("segs_valid", segs_valid, 1'b1);
        for (int k = 0; k < N; k++) begin
            exp_seg = (k < ncap) ? pd[k] : '0;
            check($sformatf("seg%0d", k), tdata_segs[k*W +: W], exp_seg);
        end
        check("seg_cnt", 512'(seg_cnt), 512'(ncap));
        check("last_tkeep", last_tkeep, pk[ncap-1]);
        check("truncated", truncated, (plen > N));
        check("tuser_1st", tuser_1st, pu[0]);
    endtask

    // Holds segs_ready low for hold cycles, then completes the handshake
    task automatic release_bundle(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge axis_clk);
            #1;
            check("bp_tready_low", s_axis_tready, 1'b0);
            check("bp_valid_held", segs_valid, 1'b1);
            check("bp_seg0_stable", tdata_segs[0 +: W], pd[0]);
        end
        segs_ready = 1'b1;
        @(posedge axis_clk);
        #1;
        segs_ready = 1'b0;
        check("hs_valid_clear", segs_valid, 1'b0);
        check("hs_tready_rise", s_axis_tready, 1'b1);
        check("vlan_valid_one_cycle", vlan_valid, 1'b0);
        check("vlan_hold", vlan, exp_vlan);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tready"}, s_axis_tready, 1'b0);
        check({tag, "_segs_valid"}, segs_valid, 1'b0);
        for (int k = 0; k < N; k++) check($sformatf("%s_seg%0d", tag, k), tdata_segs[k*W +: W], '0);
        check({tag, "_tuser"}, tuser_1st, '0);
        check({tag, "_seg_cnt"}, seg_cnt, '0);
        check({tag, "_last_tkeep"}, last_tkeep, '0);
        check({tag, "_truncated"}, truncated, 1'b0);
        check({tag, "_vlan"}, vlan, '0);
        check({tag, "_vlan_valid"}, vlan_valid, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, then tready rises on the first edge after release
        #12;
        check_all_zero("reset");
        @(negedge axis_clk);
        aresetn = 1'b1;
        #1;
        check("tready_before_edge", s_axis_tready, 1'b0);
        @(posedge axis_clk);
        #1;
        check("tready_after_release", s_axis_tready, 1'b1);

        // Single one-beat packet with segs_ready already high
        segs_ready = 1'b1;
        make_pkt(1);
        send_pkt(1);
        check_fields();
        @(posedge axis_clk);
        #1;
        check("short_consumed", segs_valid, 1'b0);
        check("short_tready", s_axis_tready, 1'b1);
        segs_ready = 1'b0;

        // Exact fit with beats 0xA..0xD
        make_pkt(4);
        for (int k = 0; k < 4; k++) pd[k] = W'(32'hA + k);
        send_pkt(4);
        check_fields();
        release_bundle(2);

        // Truncation: 7 beats, drain 4..6 then back to idle
        make_pkt(7);
        send_pkt(7);
        check_fields();
        release_bundle(1);

        // Backpressure with a second packet waiting
        make_pkt(3);
        send_pkt(3);
        check_fields();
        s_axis_tdata  = rand_beat();
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        release_bundle(10);
        make_pkt(2);
        send_pkt(2);
        check_fields();
        release_bundle(0);

        // Handshake while draining must not disturb the drain
        segs_ready = 1'b1;
        make_pkt(6);
        send_pkt(6);
        check("drain_hs_valid", segs_valid, 1'b0);
        check("drain_hs_tready", s_axis_tready, 1'b1);
        segs_ready = 1'b0;

        // VLAN field
        make_pkt(2);
        pd[0][VO +: 12] = 12'h123;
        send_pkt(2);
        check_fields();
        release_bundle(1);

        // Random packets against the packet-level model
        for (int p = 0; p < 20; p++) begin
            make_pkt(int'($urandom_range(1, 7)));
            send_pkt(plen);
            check_fields();
            release_bundle(int'($urandom_range(0, 3)));
        end

        // Reset during COLLECT, then next beat is segment 0
        make_pkt(4);
        send_pkt(2);
        s_axis_tdata  = pd[2];
        s_axis_tvalid = 1'b1;
        @(negedge axis_clk);
        aresetn = 1'b0;
        #1;
        exp_vlan = '0;
        check_all_zero("midrst");
        s_axis_tvalid = 1'b0;
        @(negedge axis_clk);
        aresetn = 1'b1;
        @(posedge axis_clk);
        #1;
        check("midrst_tready", s_axis_tready, 1'b1);
        make_pkt(2);
        send_pkt(2);
        check_fields();
        release_bundle(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
